// File: rtl/edge_result_serializer_pkg.sv
// Shared decoder constants: stage codes, the serializer state encoding and
// the word-count helper used to size the result stream.
package edge_result_serializer_pkg;

    localparam int STAGE_WIDTH = 3;

    localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE         = 3'd0;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT  = 3'd1;
    localparam logic [STAGE_WIDTH-1:0] STAGE_GROW         = 3'd2;
    localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE        = 3'd3;
    localparam logic [STAGE_WIDTH-1:0] STAGE_PEEL         = 3'd4;
    localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID = 3'd5;

    typedef enum logic [1:0] {
        SER_IDLE      = 2'd0,
        SER_SEND_HDR  = 2'd1,
        SER_SEND_DATA = 2'd2
    } ser_state_t;

    // Number of OUT_WIDTH words needed to carry num_edges bits (ceiling divide).
    function automatic int num_words(input int num_edges, input int out_width);
        return (num_edges + out_width - 1) / out_width;
    endfunction

endpackage

// File: rtl/edge_result_serializer_popcount_tree.sv
// Combinational population count of a bit vector, reusable by any result path.
module popcount_tree #(
    parameter int WIDTH = 12,
    parameter int COUNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]   bits,
    output logic [COUNT_W-1:0] count
);

    // Sum every input bit; synthesis restructures the sum into a balanced adder tree.
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + COUNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/edge_result_serializer.sv
// Snapshots the per-edge error vector on entry into the result-valid stage and
// streams it as a header word (error count) followed by the packed error bits.
// Stream handshake: a word moves only on a cycle with out_valid && out_ready;
// once raised, out_valid holds and out_data/out_last/out_context stay stable
// until that handshake.
module edge_result_serializer
    import edge_result_serializer_pkg::*;
#(
    parameter int NUM_EDGES     = 12,
    parameter int OUT_WIDTH     = 8,
    parameter int CONTEXT_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [STAGE_WIDTH-1:0]   global_stage,
    input  logic [NUM_EDGES-1:0]     edge_is_error,
    input  logic [CONTEXT_WIDTH-1:0] context_id,
    output logic [OUT_WIDTH-1:0]     out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [CONTEXT_WIDTH-1:0] out_context,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam int NUM_WORDS = num_words(NUM_EDGES, OUT_WIDTH);
    localparam int SNAP_W    = NUM_WORDS * OUT_WIDTH;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int CNT_W     = $clog2(NUM_EDGES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    ser_state_t               state, state_next;
    logic [STAGE_WIDTH-1:0]   stage, last_stage;
    logic [SNAP_W-1:0]        snapshot;
    logic [CNT_W-1:0]         header;
    logic [CNT_W-1:0]         err_count;
    logic [IDX_W-1:0]         index;
    logic                     capture_req;
    logic                     data_hs;

    popcount_tree #(
        .WIDTH   (NUM_EDGES),
        .COUNT_W (CNT_W)
    ) u_popcount (
        .bits  (edge_is_error),
        .count (err_count)
    );

    // One request per entry into the result-valid stage.
    assign capture_req = (stage == STAGE_RESULT_VALID) && (last_stage != STAGE_RESULT_VALID);
    // In SEND_DATA out_valid is always high, so ready alone completes a data word.
    assign data_hs     = (state == SER_SEND_DATA) && out_ready;
    assign busy        = (state != SER_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SER_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and stream word selection.
    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        case (state)
            SER_IDLE: begin
                if (capture_req) begin
                    state_next = SER_SEND_HDR;
                end
            end
            SER_SEND_HDR: begin
                out_valid = 1'b1;
                out_data  = OUT_WIDTH'(header);
                if (out_ready) begin
                    state_next = SER_SEND_DATA;
                end
            end
            SER_SEND_DATA: begin
                out_valid = 1'b1;
                out_data  = snapshot[int'(index) * OUT_WIDTH +: OUT_WIDTH];
                out_last  = (index == LAST_IDX);
                if (out_ready && (index == LAST_IDX)) begin
                    state_next = SER_IDLE;
                end
            end
            default: begin
                state_next = SER_IDLE;
            end
        endcase
    end

    // Stage tracking, snapshot capture, word index, done pulse and sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage       <= STAGE_IDLE;
            last_stage  <= STAGE_IDLE;
            snapshot    <= '0;
            header      <= '0;
            index       <= '0;
            out_context <= '0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            stage      <= global_stage;
            last_stage <= stage;
            done       <= 1'b0;
            if (capture_req && (state == SER_IDLE)) begin
                snapshot    <= SNAP_W'(edge_is_error);
                header      <= err_count;
                index       <= '0;
                out_context <= context_id;
            end
            if (capture_req && (state != SER_IDLE)) begin
                overrun <= 1'b1;
            end
            if (data_hs) begin
                if (index == LAST_IDX) begin
                    index <= '0;
                    done  <= 1'b1;
                end else begin
                    index <= index + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_result_serializer.sv
// Bench for edge_result_serializer: directed scenarios plus randomized results,
// each stream compared against an expected word queue built from the error vector.
module tb_edge_result_serializer;
    import edge_result_serializer_pkg::*;

    localparam int NE = 12;
    localparam int OW = 8;
    localparam int CW = 2;
    localparam int NW = (NE + OW - 1) / OW;
    localparam int EW = 1 + CW + OW;

    logic                   clk;
    logic                   reset;
    logic [STAGE_WIDTH-1:0] global_stage;
    logic [NE-1:0]          edge_is_error;
    logic [CW-1:0]          context_id;
    logic [OW-1:0]          out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic [CW-1:0]          out_context;
    logic                   busy;
    logic                   done;
    logic                   overrun;

    int checks = 0;
    int errors = 0;
    logic          exp_overrun;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];

    edge_result_serializer #(
        .NUM_EDGES     (NE),
        .OUT_WIDTH     (OW),
        .CONTEXT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .global_stage  (global_stage),
        .edge_is_error (edge_is_error),
        .context_id    (context_id),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .out_context   (out_context),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: header = number of set bits, then the vector in OW-bit chunks, LSB first.
    function automatic void build_exp(input logic [NE-1:0] vec, input logic [CW-1:0] ctx);
        longint unsigned v;
        logic [OW-1:0]   w;
        v = 64'(vec);
        exp_q.push_back({1'b0, ctx, OW'($countones(vec))});
        for (int i = 0; i < NW; i++) begin
            w = OW'((v >> (i * OW)) % (64'd1 << OW));
            exp_q.push_back({(i == NW - 1), ctx, w});
        end
    endfunction

    // Pulse the stage into RESULT_VALID for one cycle; capture lands on the following edge.
    task automatic pulse_stage(input logic [NE-1:0] vec, input logic [CW-1:0] ctx);
        edge_is_error = vec;
        context_id    = ctx;
        global_stage  = STAGE_RESULT_VALID;
        step();
        global_stage  = STAGE_IDLE;
        step();
    endtask

    // Enter the result stage from idle and check the header appears one cycle after capture.
    task automatic enter_result(input logic [NE-1:0] vec, input logic [CW-1:0] ctx);
        edge_is_error = vec;
        context_id    = ctx;
        global_stage  = STAGE_RESULT_VALID;
        step();
        global_stage  = STAGE_IDLE;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pre_capture: valid=%b busy=%b required valid=0 busy=0", out_valid, busy);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL capture_latency: valid=%b busy=%b last=%b required 1 1 0", out_valid, busy, out_last);
        end
        checks++;
        if (out_data !== OW'($countones(vec)) || out_context !== ctx) begin
            errors++;
            $display("FAIL header: data=%0h ctx=%0d required data=%0h ctx=%0d",
                     out_data, out_context, OW'($countones(vec)), ctx);
        end
    endtask

    // Drain one stream under a ready pattern, checking hold stability and done timing,
    // then compare every transferred word with the expected queue.
    task automatic run_stream(input int mode, input string name);
        logic [OW-1:0] p_data;
        logic          p_last;
        logic [CW-1:0] p_ctx;
        logic          p_hold;
        logic          last_hs;
        bit            finished;
        int            k;
        finished = 0;
        k = 0;
        while (k < 200 && !finished) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((k % 6) == 5);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            p_hold  = out_valid && !out_ready;
            p_data  = out_data;
            p_last  = out_last;
            p_ctx   = out_context;
            last_hs = out_valid && out_ready && out_last;
            if (out_valid && out_ready) got_q.push_back({out_last, out_context, out_data});
            step();
            if (p_hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== p_data || out_last !== p_last || out_context !== p_ctx) begin
                    errors++;
                    $display("FAIL %s hold: valid=%b data=%0h last=%b ctx=%0d required 1 %0h %b %0d",
                             name, out_valid, out_data, out_last, out_context, p_data, p_last, p_ctx);
                end
            end
            checks++;
            if (done !== last_hs) begin
                errors++;
                $display("FAIL %s done_timing: done=%b required %b", name, done, last_hs);
            end
            if (done === 1'b1) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_busy: busy=%b required 0", name, busy);
                end
            end
            if (last_hs) finished = 1;
            k++;
        end
        out_ready = 1'b0;
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout: stream incomplete after %0d cycles, required completion", name, k);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s word_count: got %0d words required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s word%0d: {last,ctx,data}=%0h required %0h", name, i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (overrun !== exp_overrun) begin
            errors++;
            $display("FAIL %s overrun: %b required %b", name, overrun, exp_overrun);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        global_stage  = STAGE_IDLE;
        edge_is_error = '0;
        context_id    = '0;
        out_ready     = 1'b0;
        exp_overrun   = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b last=%b busy=%b done=%b overrun=%b required all 0",
                     out_valid, out_last, busy, done, overrun);
        end
        checks++;
        if (out_data !== '0 || out_context !== '0) begin
            errors++;
            $display("FAIL reset_data: data=%0h ctx=%0d required 0 0", out_data, out_context);
        end
    endtask

    task automatic test_basic();
        build_exp(12'hA51, 2'd2);
        enter_result(12'hA51, 2'd2);
        run_stream(0, "basic");
    endtask

    task automatic test_backpressure();
        build_exp(12'hA51, 2'd2);
        enter_result(12'hA51, 2'd2);
        run_stream(1, "backpressure");
    endtask

    task automatic test_zero_errors();
        build_exp(12'h000, 2'd1);
        enter_result(12'h000, 2'd1);
        run_stream(0, "zero");
    endtask

    task automatic test_reentry_busy();
        logic [NE-1:0] vec1;
        logic [NE-1:0] vec3;
        vec1 = NE'($urandom_range(0, 4095));
        vec3 = NE'($urandom_range(0, 4095));
        out_ready = 1'b0;
        build_exp(vec1, 2'd3);
        enter_result(vec1, 2'd3);
        step();
        pulse_stage(~vec1, 2'd0);
        exp_overrun = 1'b1;
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reentry_flag: overrun=%b busy=%b required 1 1", overrun, busy);
        end
        checks++;
        if (out_data !== OW'($countones(vec1)) || out_context !== 2'd3) begin
            errors++;
            $display("FAIL reentry_hold: data=%0h ctx=%0d required %0h 3", out_data, out_context, OW'($countones(vec1)));
        end
        run_stream(0, "reentry_first");
        build_exp(vec3, 2'd1);
        enter_result(vec3, 2'd1);
        run_stream(2, "reentry_next");
    endtask

    task automatic test_reset_mid_stream();
        logic [NE-1:0] vec;
        vec = 12'h3C6;
        build_exp(vec, 2'd2);
        enter_result(vec, 2'd2);
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_q[1][OW-1:0]) begin
            errors++;
            $display("FAIL midreset_first_word: valid=%b data=%0h required 1 %0h", out_valid, out_data, exp_q[1][OW-1:0]);
        end
        exp_q.delete();
        out_ready = 1'b0;
        reset     = 1'b1;
        step();
        reset       = 1'b0;
        exp_overrun = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flags: valid=%b busy=%b overrun=%b done=%b required all 0",
                     out_valid, busy, overrun, done);
        end
        checks++;
        if (out_data !== '0 || out_context !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL midreset_data: data=%0h ctx=%0d last=%b required 0 0 0", out_data, out_context, out_last);
        end
        build_exp(12'h5A9, 2'd0);
        enter_result(12'h5A9, 2'd0);
        run_stream(0, "after_reset");
    endtask

    task automatic test_all_ones();
        build_exp(12'hFFF, 2'd3);
        enter_result(12'hFFF, 2'd3);
        run_stream(0, "all_ones");
    endtask

    task automatic test_random();
        logic [NE-1:0] vec;
        logic [CW-1:0] ctx;
        for (int n = 0; n < 12; n++) begin
            vec = NE'($urandom_range(0, 4095));
            ctx = CW'($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) step();
            build_exp(vec, ctx);
            enter_result(vec, ctx);
            run_stream(int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_errors();
        test_reentry_busy();
        test_reset_mid_stream();
        test_all_ones();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_result_serializer.md
Name: edge_result_serializer

Overview:
- Downstream consumer of the per-edge `is_error` outputs of the internal neighbour links.
- When the decoder enters the result-valid stage, it snapshots the error vector of all `NUM_EDGES` links for the current context, then streams it out over a valid/ready word interface.
- The stream is a header word (error count) followed by the packed error bits.
- It sits between the link array and the result/output FIFO logic of the decoder top.

Parameters:
- `NUM_EDGES`, 12, number of link `is_error` bits captured per result.
- `OUT_WIDTH`, 8, output word width in bits. Must be ≥ $clog2(NUM_EDGES+1).
- `CONTEXT_WIDTH`, 2, width of the context identifier carried as sideband.

Ports:
- `clk`  input  1  clock
- `reset`  input  1  synchronous, active-high reset
- `global_stage`  input  STAGE_WIDTH  decoder stage code (shared stage constants)
- `edge_is_error`  input  NUM_EDGES  `is_error` of each link; bit i = edge i
- `context_id`  input  CONTEXT_WIDTH  context currently resident in the array
- `out_data`  output  OUT_WIDTH  stream word
- `out_valid`  output  1  word valid
- `out_ready`  input  1  consumer accepts word
- `out_last`  output  1  marks final word of a result
- `out_context`  output  CONTEXT_WIDTH  context of the result being streamed
- `busy`  output  1  high from capture until final handshake
- `done`  output  1  one-cycle pulse on the cycle after the final handshake
- `overrun`  output  1  sticky: a capture request arrived while busy

Behaviour:
- **Stage tracking.** `stage` <= `global_stage`, `last_stage` <= `stage` (registered, both reset to STAGE_IDLE).
- **Capture request.** Asserted when `stage == STAGE_RESULT_VALID` and `last_stage != STAGE_RESULT_VALID`; one request per entry into the stage.
- **Derived constant.** `NUM_WORDS = ceil(NUM_EDGES/OUT_WIDTH)`. The snapshot register is `NUM_WORDS*OUT_WIDTH` wide; bits above `NUM_EDGES` are zero-padded.
- **FSM states: IDLE, SEND_HDR, SEND_DATA.**
  - IDLE, capture request:
    - latch `edge_is_error` into the snapshot, `context_id` into `out_context`;
    - register popcount(`edge_is_error`) into the header;
    - word index <= 0;
    - -> SEND_HDR.
  - `out_valid` is high the cycle after capture (capture-to-valid latency 1).
  - SEND_HDR:
    - `out_data` = popcount zero-extended to OUT_WIDTH, `out_last` = 0.
    - On `out_valid && out_ready` -> SEND_DATA.
  - SEND_DATA:
    - `out_data` = snapshot[index*OUT_WIDTH +: OUT_WIDTH], LSB-first.
    - `out_last` = (index == NUM_WORDS-1).
    - On handshake: index++, or on the last word -> IDLE and `done` pulses next cycle.
- **Handshake rules.**
  - `out_data`, `out_last` and `out_context` are stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a handshake.
  - A word is transferred only on a cycle where both `out_valid` and `out_ready` are high.
- **Busy.** `busy` = (state != IDLE). `done` is not asserted together with `busy`.
- **Capture while busy.** A capture request while not in IDLE is ignored: the snapshot is untouched and `overrun` is set to 1 and held until reset.
- **Zero errors.** An all-zero error vector still produces a full stream: header 0 plus `NUM_WORDS` zero words.
- **Stage changes mid-stream.** Leaving STAGE_RESULT_VALID during a stream does not abort it; the stream completes on its own handshakes.
- **Reset (including mid-stream).** All of the following are 0 on the cycle after reset:
  - `out_valid`, `out_last`, `busy`, `done`, `overrun`;
  - `out_data`, `out_context`, snapshot, index, header;
  - state = IDLE.
- **Counter widths.**
  - Word index width: $clog2(NUM_WORDS) (minimum 1).
  - Popcount width: $clog2(NUM_EDGES+1), computed as a combinational adder tree over the input at capture.

Decomposition:
- **Shared parameters package:** STAGE_WIDTH and the STAGE_* codes (already shared), plus a new `SER_STATE` encoding (IDLE=0, SEND_HDR=1, SEND_DATA=2) and the `NUM_WORDS` derivation macro.
- **Sub-module:** one, `popcount_tree` (parameter WIDTH; combinational sum of bits), reusable by other result paths.

Test Plan:
1. **Basic stream.** NUM_EDGES=12, OUT_WIDTH=8; `edge_is_error`=12'hA51, `context_id`=2, enter RESULT_VALID, `out_ready`=1 → words 0x05, 0x51, 0x0A with `out_last` only on 0x0A; `out_context`=2; `done` pulse 1 cycle after the third handshake.
2. **Backpressure.** Same vector; hold `out_ready`=0 for 5 cycles on each word → `out_valid` stays 1, `out_data` is stable, and words and order are identical to scenario 1.
3. **Zero-error result.** `edge_is_error`=0 → stream 0x00, 0x00, 0x00; `out_last` on the third word; `overrun`=0.
4. **Re-entry while busy.** Stage leaves and re-enters RESULT_VALID while `out_ready`=0 holding the header → `overrun`=1, streamed data still the first snapshot; a new entry after `done` captures normally.
5. **Reset mid-stream.** Assert `reset` for 1 cycle after the header handshake → next cycle `out_valid`=0, `busy`=0, `overrun`=0; a following entry streams the complete new result starting from the header.
6. **All ones.** `edge_is_error`=12'hFFF → header 0x0C, then 0xFF, 0x0F (pad bits zero).
